// File: rtl/phy_lane_reconfig_ctrl.sv
// CSR-driven reconfiguration sequencer: single read / write / masked RMW onto a shared
// multi-lane Avalon-MM reconfig master, with phase timeout, bad-lane rejection and lane IRQs.
module phy_lane_reconfig_ctrl #(
    parameter int LANES   = 4,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 1023,
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                     clk125_clk,
    input  logic                     reset_reset,
    input  logic [3:0]               csr_address,
    input  logic                     csr_read,
    input  logic                     csr_write,
    input  logic [31:0]              csr_writedata,
    output logic [31:0]              csr_readdata,
    output logic                     csr_readdatavalid,
    output logic                     csr_waitrequest,
    output logic [LANE_W+ADDR_W-1:0] m0_address,
    output logic                     m0_read,
    output logic                     m0_write,
    output logic [31:0]              m0_writedata,
    input  logic                     m0_waitrequest,
    input  logic [31:0]              m0_readdata,
    input  logic                     m0_readdatavalid,
    input  logic [LANES-1:0]         lane_irq,
    output logic                     irq
);

    typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_DONE} state_t;

    localparam logic [3:0] A_ADDR     = 4'h0;
    localparam logic [3:0] A_WDATA    = 4'h1;
    localparam logic [3:0] A_CMD      = 4'h2;
    localparam logic [3:0] A_MASK     = 4'h3;
    localparam logic [3:0] A_STATUS   = 4'h4;
    localparam logic [3:0] A_RDATA    = 4'h5;
    localparam logic [3:0] A_IRQ_PEND = 4'h6;
    localparam logic [3:0] A_IRQ_MASK = 4'h7;
    localparam logic [3:0] A_VERSION  = 4'h8;
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

    state_t                    state_q, state_d;
    logic [15:0]               cnt_q, cnt_d;
    logic [7:0]                lane_q, lane_d;
    logic [ADDR_W-1:0]         reg_q, reg_d;
    logic [31:0]               wdata_q, wdata_d;
    logic [31:0]               mask_q, mask_d;
    logic [31:0]               rdata_q, rdata_d;
    logic [LANE_W+ADDR_W-1:0]  op_addr_q, op_addr_d;
    logic [31:0]               op_mask_q, op_mask_d;
    logic [31:0]               m0_wdata_q, m0_wdata_d;
    logic                      op_rmw_q, op_rmw_d;
    logic                      done_q, done_d;
    logic                      tmo_q, tmo_d;
    logic                      bad_q, bad_d;
    logic                      ovr_q, ovr_d;
    logic [LANES-1:0]          pend_q, pend_d;
    logic [LANES-1:0]          irqmask_q, irqmask_d;
    logic [LANES-1:0]          prev_q, prev_d;
    logic                      irq_q, irq_d;
    logic [31:0]               rd_q, rd_d;
    logic                      rdv_q, rdv_d;

    logic cmd_wr, accept, lane_bad, busy;

    assign busy     = (state_q != S_IDLE);
    assign cmd_wr   = csr_write && (csr_address == A_CMD);
    assign accept   = cmd_wr && (|csr_writedata[2:0]) && !busy;
    assign lane_bad = 32'(lane_q) >= 32'(LANES);

    // CSR register file and interrupt latching
    always_comb begin
        lane_d    = lane_q;
        reg_d     = reg_q;
        wdata_d   = wdata_q;
        mask_d    = mask_q;
        irqmask_d = irqmask_q;
        pend_d    = pend_q;
        prev_d    = lane_irq;
        if (csr_write) begin
            case (csr_address)
                A_ADDR: begin
                    lane_d = csr_writedata[31:24];
                    reg_d  = csr_writedata[ADDR_W-1:0];
                end
                A_WDATA:    wdata_d   = csr_writedata;
                A_MASK:     mask_d    = csr_writedata;
                A_IRQ_PEND: pend_d    = pend_q & ~csr_writedata[LANES-1:0];
                A_IRQ_MASK: irqmask_d = csr_writedata[LANES-1:0];
                default: ;
            endcase
        end
        // a fresh rising edge beats a same-cycle clear
        pend_d = pend_d | (lane_irq & ~prev_q);
        irq_d  = |(pend_q & irqmask_q);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        rdata_d    = rdata_q;
        op_addr_d  = op_addr_q;
        op_mask_d  = op_mask_q;
        m0_wdata_d = m0_wdata_q;
        op_rmw_d   = op_rmw_q;
        done_d     = done_q;
        tmo_d      = tmo_q;
        bad_d      = bad_q;
        ovr_d      = ovr_q;
        if (accept) begin
            done_d = 1'b0;
            tmo_d  = 1'b0;
            bad_d  = 1'b0;
            ovr_d  = 1'b0;
        end
        if (cmd_wr && busy) ovr_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (lane_bad) begin
                        bad_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        // operands are frozen here so CSR writes mid-op cannot disturb the bus
                        op_addr_d  = {lane_q[LANE_W-1:0], reg_q};
                        op_mask_d  = mask_q;
                        m0_wdata_d = wdata_q;
                        op_rmw_d   = csr_writedata[2];
                        state_d    = (csr_writedata[2] || !csr_writedata[1]) ? S_RD_REQ : S_WR_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                if (!m0_waitrequest) begin
                    state_d = S_RD_WAIT;
                end else if (cnt_q == TO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_RD_WAIT: begin
                if (m0_readdatavalid) begin
                    rdata_d = m0_readdata;
                    if (op_rmw_q) begin
                        m0_wdata_d = (m0_readdata & ~op_mask_q) | (m0_wdata_q & op_mask_q);
                        state_d    = S_WR_REQ;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (cnt_q == TO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WR_REQ: begin
                if (!m0_waitrequest) begin
                    state_d = S_DONE;
                end else if (cnt_q == TO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == state_q &&
            (state_q == S_RD_REQ || state_q == S_RD_WAIT || state_q == S_WR_REQ))
            cnt_d = cnt_q + 16'd1;
    end

    always_comb begin
        rd_d  = '0;
        rdv_d = csr_read;
        if (csr_read) begin
            case (csr_address)
                A_ADDR:     rd_d = {lane_q, 8'h00, 16'(reg_q)};
                A_WDATA:    rd_d = wdata_q;
                A_MASK:     rd_d = mask_q;
                A_STATUS:   rd_d = {27'd0, ovr_q, bad_q, tmo_q, done_q, busy};
                A_RDATA:    rd_d = rdata_q;
                A_IRQ_PEND: rd_d = 32'(pend_q);
                A_IRQ_MASK: rd_d = 32'(irqmask_q);
                A_VERSION:  rd_d = 32'h0002_0000 | 32'(LANES);
                default:    rd_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk125_clk) begin
        if (reset_reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            lane_q     <= '0;
            reg_q      <= '0;
            wdata_q    <= '0;
            mask_q     <= '0;
            rdata_q    <= '0;
            op_addr_q  <= '0;
            op_mask_q  <= '0;
            m0_wdata_q <= '0;
            op_rmw_q   <= 1'b0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
            bad_q      <= 1'b0;
            ovr_q      <= 1'b0;
            pend_q     <= '0;
            irqmask_q  <= '0;
            prev_q     <= '0;
            irq_q      <= 1'b0;
            rd_q       <= '0;
            rdv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lane_q     <= lane_d;
            reg_q      <= reg_d;
            wdata_q    <= wdata_d;
            mask_q     <= mask_d;
            rdata_q    <= rdata_d;
            op_addr_q  <= op_addr_d;
            op_mask_q  <= op_mask_d;
            m0_wdata_q <= m0_wdata_d;
            op_rmw_q   <= op_rmw_d;
            done_q     <= done_d;
            tmo_q      <= tmo_d;
            bad_q      <= bad_d;
            ovr_q      <= ovr_d;
            pend_q     <= pend_d;
            irqmask_q  <= irqmask_d;
            prev_q     <= prev_d;
            irq_q      <= irq_d;
            rd_q       <= rd_d;
            rdv_q      <= rdv_d;
        end
    end

    assign csr_readdata      = rd_q;
    assign csr_readdatavalid = rdv_q;
    assign csr_waitrequest   = 1'b0;
    assign m0_address        = op_addr_q;
    assign m0_read           = (state_q == S_RD_REQ);
    assign m0_write          = (state_q == S_WR_REQ);
    assign m0_writedata      = m0_wdata_q;
    assign irq               = irq_q;

endmodule

// File: tb/tb_phy_lane_reconfig_ctrl.sv
// Bench for phy_lane_reconfig_ctrl: directed scenarios plus random ops against a memory-backed
// reference model; a responder process plays the reconfig slave.
module tb_phy_lane_reconfig_ctrl;
    localparam int LANES = 4, ADDR_W = 10, TIMEOUT = 8;
    localparam int AW = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        csr_address;
    logic              csr_read, csr_write;
    logic [31:0]       csr_writedata, csr_readdata;
    logic              csr_readdatavalid, csr_waitrequest;
    logic [AW-1:0]     m0_address;
    logic              m0_read, m0_write;
    logic [31:0]       m0_writedata, m0_readdata;
    logic              m0_waitrequest, m0_readdatavalid;
    logic [LANES-1:0]  lane_irq;
    logic              irq;

    phy_lane_reconfig_ctrl #(.LANES(LANES), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk125_clk(clk), .reset_reset(rst),
        .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
        .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
        .csr_readdatavalid(csr_readdatavalid), .csr_waitrequest(csr_waitrequest),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .lane_irq(lane_irq), .irq(irq)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // slave memory (written only by the main process) and responder controls
    logic [31:0]  mem [0:(1<<AW)-1];
    int unsigned  slv_wait = 0;
    bit           slv_stuck = 0, slv_mute = 0;
    int unsigned  inj_req = 0;
    logic [31:0]  inj_data = '0;

    // responder-owned observations
    int unsigned  cyc = 0, rd_acc = 0, wr_acc = 0, cur_len = 0, last_len = 0, req_cycles = 0;
    int unsigned  t_rvalid = 0, t_wr_first = 0, inj_done = 0, wcnt = 0;
    logic [AW-1:0] last_rd_addr = '0, last_wr_addr = '0, acc_addr = '0, prev_addr = '0;
    logic [31:0]  last_wr_data = '0, prev_wd = '0;
    bit           acc_rd = 0, prev_req = 0, unstable = 0;

    initial begin
        m0_waitrequest   = 1'b1;
        m0_readdata      = '0;
        m0_readdatavalid = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            m0_readdatavalid = 1'b0;
            if (acc_rd) begin
                acc_rd = 0;
                if (!slv_mute) begin
                    m0_readdata      = mem[acc_addr];
                    m0_readdatavalid = 1'b1;
                    t_rvalid         = cyc;
                end
            end else if (inj_req != inj_done) begin
                inj_done         = inj_req;
                m0_readdata      = inj_data;
                m0_readdatavalid = 1'b1;
            end
            if (m0_read || m0_write) begin
                if (prev_req && (m0_address !== prev_addr || m0_writedata !== prev_wd)) unstable = 1;
                if (cur_len == 0 && m0_write) t_wr_first = cyc;
                cur_len++;
                req_cycles++;
                if (!slv_stuck && wcnt >= slv_wait) begin
                    m0_waitrequest = 1'b0;
                    wcnt = 0;
                    if (m0_read) begin
                        acc_rd = 1;
                        acc_addr = m0_address;
                        last_rd_addr = m0_address;
                        rd_acc++;
                    end else begin
                        last_wr_addr = m0_address;
                        last_wr_data = m0_writedata;
                        wr_acc++;
                    end
                end else begin
                    m0_waitrequest = 1'b1;
                    wcnt++;
                end
            end else begin
                m0_waitrequest = 1'b1;
                wcnt = 0;
                if (cur_len != 0) last_len = cur_len;
                cur_len = 0;
            end
            prev_req  = m0_read || m0_write;
            prev_addr = m0_address;
            prev_wd   = m0_writedata;
        end
    end

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic csr_wr(input logic [3:0] a, input logic [31:0] d);
        csr_address = a; csr_writedata = d; csr_write = 1'b1;
        @(negedge clk);
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [3:0] a, output logic [31:0] d);
        csr_address = a; csr_read = 1'b1;
        @(negedge clk);
        csr_read = 1'b0;
        d = csr_readdatavalid ? csr_readdata : 32'hxxxx_xxxx;
    endtask

    task automatic wait_idle(output logic [31:0] st);
        st = 32'h1;
        for (int i = 0; i < 200 && st[0] === 1'b1; i++) csr_rd(4'h4, st);
        chk("op_complete", {31'd0, st[0]}, 32'd0);
    endtask

    logic [31:0]  st, rdv, wd, mk, old, nv, exp_st, model_rdata;
    logic [7:0]   lane8;
    logic [15:0]  a16;
    logic [2:0]   cmd;
    logic [AW-1:0] ea;
    int unsigned  rd0, wr0, rq0, exp_rd, exp_wr;

    initial begin
        rst = 1'b1; csr_address = '0; csr_read = 0; csr_write = 0; csr_writedata = '0; lane_irq = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'(i) * 32'h9E37_79B9 ^ 32'hA5A5_0F0F;
        repeat (3) @(negedge clk);
        chk("rst_m0_read", 32'(m0_read), 0);
        chk("rst_m0_write", 32'(m0_write), 0);
        chk("rst_m0_address", 32'(m0_address), 0);
        chk("rst_m0_writedata", m0_writedata, 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_rdvalid", 32'(csr_readdatavalid), 0);
        chk("rst_waitreq", 32'(csr_waitrequest), 0);
        rst = 1'b0;
        @(negedge clk);
        csr_rd(4'h4, rdv); chk("rst_status", rdv, 0);
        csr_rd(4'h8, rdv); chk("version", rdv, 32'h0002_0004);
        csr_rd(4'h2, rdv); chk("cmd_reads_0", rdv, 0);
        csr_rd(4'hC, rdv); chk("unmapped", rdv, 0);
        csr_wr(4'h0, 32'hABCD_FFFF);
        csr_rd(4'h0, rdv); chk("addr_readback", rdv, 32'hAB00_03FF);

        // read lane 2 / 0x05A with 3 wait cycles
        mem[12'h85A] = 32'hDEAD_BEEF; slv_wait = 3; rd0 = rd_acc;
        csr_wr(4'h0, {8'd2, 8'h00, 16'h005A});
        csr_wr(4'h2, 32'h1);
        wait_idle(st);
        chk("rd_status", st, 32'h2);
        chk("rd_addr", 32'(last_rd_addr), 32'h85A);
        chk("rd_count", rd_acc - rd0, 1);
        chk("rd_req_len", last_len, 4);
        csr_rd(4'h5, rdv); chk("rd_rdata", rdv, 32'hDEAD_BEEF);

        // zero-wait read cycle-by-cycle timing
        slv_wait = 0;
        csr_wr(4'h0, {8'd0, 8'h00, 16'h0010});
        csr_wr(4'h2, 32'h1);
        chk("t1_m0_read", 32'(m0_read), 1);
        csr_rd(4'h4, rdv); chk("t1_status", rdv, 32'h1);
        csr_rd(4'h4, rdv); chk("t2_status", rdv, 32'h1);
        csr_rd(4'h4, rdv); chk("t3_status", rdv, 32'h1);
        csr_rd(4'h4, rdv); chk("t4_status", rdv, 32'h2);
        csr_rd(4'h5, rdv); chk("t_rdata", rdv, mem[12'h010]);

        // RMW lane 1
        mem[12'h420] = 32'hFFFF_0000; rd0 = rd_acc; wr0 = wr_acc;
        csr_wr(4'h0, {8'd1, 8'h00, 16'h0020});
        csr_wr(4'h1, 32'h0000_ABCD);
        csr_wr(4'h3, 32'h00FF_00FF);
        csr_wr(4'h2, 32'h4);
        wait_idle(st);
        chk("rmw_status", st, 32'h2);
        chk("rmw_rd_count", rd_acc - rd0, 1);
        chk("rmw_wr_count", wr_acc - wr0, 1);
        chk("rmw_wdata", last_wr_data, 32'hFF00_00CD);
        chk("rmw_waddr", 32'(last_wr_addr), 32'h420);
        chk("rmw_wr_gap", t_wr_first - t_rvalid, 1);
        csr_rd(4'h5, rdv); chk("rmw_rdata", rdv, 32'hFFFF_0000);
        mem[12'h420] = 32'hFF00_00CD;

        // waitrequest stuck: timeout after TIMEOUT request cycles
        slv_stuck = 1; rd0 = rd_acc;
        csr_wr(4'h0, {8'd0, 8'h00, 16'h0005});
        csr_wr(4'h2, 32'h1);
        wait_idle(st);
        chk("tmo_status", st, 32'h6);
        chk("tmo_req_len", last_len, 8);
        chk("tmo_no_accept", rd_acc - rd0, 0);
        slv_stuck = 0; inj_data = 32'h1234_5678; inj_req++;
        repeat (3) @(negedge clk);
        csr_rd(4'h5, rdv); chk("tmo_rdata_kept", rdv, 32'hFFFF_0000);

        // bad lane
        rq0 = req_cycles;
        csr_wr(4'h0, {8'd4, 8'h00, 16'h0001});
        csr_wr(4'h2, 32'h2);
        wait_idle(st);
        chk("bad_status", st, 32'hA);
        chk("bad_no_req", req_cycles - rq0, 0);

        // CMD while busy
        slv_wait = 5; rd0 = rd_acc; wr0 = wr_acc;
        csr_wr(4'h0, {8'd3, 8'h00, 16'h03FF});
        csr_wr(4'h2, 32'h1);
        csr_wr(4'h2, 32'h2);
        wait_idle(st);
        chk("ovr_status", st, 32'h13 & 32'h12);
        chk("ovr_rd_count", rd_acc - rd0, 1);
        chk("ovr_wr_count", wr_acc - wr0, 0);
        csr_rd(4'h5, rdv); chk("ovr_rdata", rdv, mem[12'hFFF]);

        // IRQ latching
        csr_wr(4'h7, 32'h8);
        lane_irq = 4'b1000;
        @(negedge clk); chk("irq_t1", 32'(irq), 0);
        @(negedge clk); chk("irq_t2", 32'(irq), 1);
        csr_rd(4'h6, rdv); chk("pend_set", rdv, 32'h8);
        lane_irq = 4'b0000;
        @(negedge clk);
        lane_irq = 4'b1000;
        csr_wr(4'h6, 32'h8);
        csr_rd(4'h6, rdv); chk("pend_set_wins", rdv, 32'h8);
        chk("irq_held", 32'(irq), 1);
        csr_wr(4'h6, 32'h8);
        csr_rd(4'h6, rdv); chk("pend_cleared", rdv, 32'h0);
        chk("irq_cleared", 32'(irq), 0);
        lane_irq = 4'b1001;
        repeat (2) @(negedge clk);
        chk("irq_masked", 32'(irq), 0);
        csr_rd(4'h6, rdv); chk("pend_masked", rdv, 32'h1);
        lane_irq = 4'b0000;

        // reset during RD_WAIT
        slv_wait = 0; slv_mute = 1;
        csr_wr(4'h0, {8'd3, 8'h00, 16'h0155});
        csr_wr(4'h2, 32'h1);
        chk("pre_rst_addr", 32'(m0_address), 32'hD55);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_m0_read", 32'(m0_read), 0);
        chk("mid_rst_m0_write", 32'(m0_write), 0);
        chk("mid_rst_m0_address", 32'(m0_address), 0);
        chk("mid_rst_irq", 32'(irq), 0);
        rst = 1'b0; slv_mute = 0;
        csr_rd(4'h4, rdv); chk("post_rst_status", rdv, 0);
        csr_rd(4'h5, rdv); chk("post_rst_rdata", rdv, 0);
        csr_wr(4'h0, {8'd3, 8'h00, 16'h0155});
        csr_wr(4'h2, 32'h1);
        wait_idle(st);
        chk("post_rst_rd_status", st, 32'h2);
        model_rdata = mem[12'hD55];
        csr_rd(4'h5, rdv); chk("post_rst_rd_rdata", rdv, model_rdata);

        // random operations against the memory model
        for (int n = 0; n < 24; n++) begin
            lane8 = 8'($urandom_range(0, 4));
            a16   = 16'($urandom);
            cmd   = 3'($urandom_range(1, 7));
            wd    = $urandom;
            mk    = $urandom;
            slv_wait = $urandom_range(0, 3);
            ea = {lane8[1:0], a16[9:0]};
            csr_wr(4'h0, {lane8, 8'h00, a16});
            csr_wr(4'h1, wd);
            csr_wr(4'h3, mk);
            rd0 = rd_acc; wr0 = wr_acc;
            csr_wr(4'h2, {29'd0, cmd});
            wait_idle(st);
            exp_rd = 0; exp_wr = 0; exp_st = 32'h2;
            if (lane8 >= 8'(LANES)) begin
                exp_st = 32'hA;
            end else if (cmd[2]) begin
                old = mem[ea];
                nv  = (old & ~mk) | (wd & mk);
                exp_rd = 1; exp_wr = 1; model_rdata = old;
                chk("rnd_rmw_wdata", last_wr_data, nv);
                chk("rnd_rmw_waddr", 32'(last_wr_addr), 32'(ea));
                mem[ea] = nv;
            end else if (cmd[1]) begin
                exp_wr = 1;
                chk("rnd_wr_wdata", last_wr_data, wd);
                chk("rnd_wr_waddr", 32'(last_wr_addr), 32'(ea));
                mem[ea] = wd;
            end else begin
                exp_rd = 1; model_rdata = mem[ea];
                chk("rnd_rd_addr", 32'(last_rd_addr), 32'(ea));
            end
            chk("rnd_status", st, exp_st);
            chk("rnd_rd_count", rd_acc - rd0, exp_rd);
            chk("rnd_wr_count", wr_acc - wr0, exp_wr);
            csr_rd(4'h5, rdv); chk("rnd_rdata", rdv, model_rdata);
        end

        chk("bus_stable", 32'(unstable), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/phy_lane_reconfig_ctrl.md
# phy_lane_reconfig_ctrl

Parametrised multi-lane reconfiguration controller for the Interlaken PHY subsystem. A 32-bit Avalon-MM CSR slave (host side) sequences single reads, writes and masked read-modify-write (RMW) operations onto one shared Avalon-MM reconfiguration master that addresses LANES transceiver channels. It replaces per-lane hand-driven reconfig accesses. It adds:
- timeout recovery,
- bad-lane rejection,
- per-lane interrupt latching with mask and aggregation.

## Interface
Parameters:
- LANES, 4, number of transceiver lanes (1..16)
- ADDR_W, 10, per-lane reconfig register address width (1..16)
- TIMEOUT, 1023, max cycles per master transaction phase before abort (1..65535)
- LANE_W, derived, max(1, clog2(LANES)); not user-set

Ports:
- clk125_clk  in  1  sole clock; all logic on rising edge
- reset_reset  in  1  synchronous, active-high reset
- csr_address  in  4  CSR word address
- csr_read  in  1  CSR read strobe
- csr_write  in  1  CSR write strobe
- csr_writedata  in  32  CSR write data
- csr_readdata  out  32  CSR read data
- csr_readdatavalid  out  1  read data valid
- csr_waitrequest  out  1  tied 0
- m0_address  out  LANE_W+ADDR_W  {lane, reg addr}
- m0_read  out  1  master read request
- m0_write  out  1  master write request
- m0_writedata  out  32  master write data
- m0_waitrequest  in  1  slave stall
- m0_readdata  in  32  master read data
- m0_readdatavalid  in  1  master read data valid
- lane_irq  in  LANES  per-lane level interrupt, synchronous to clk125_clk
- irq  out  1  aggregated interrupt

## Operation
CSR map (word addresses):
- 0x0 ADDR: [31:24] lane, [15:0] reg addr (upper bits beyond ADDR_W ignored)
- 0x1 WDATA
- 0x2 CMD (write-only; reads 0): bit0 READ, bit1 WRITE, bit2 RMW. If several bits are set, priority is RMW > WRITE > READ.
- 0x3 RMW_MASK
- 0x4 STATUS (RO):
  - bit0 busy
  - bit1 done (sticky)
  - bit2 timeout (sticky)
  - bit3 bad_lane (sticky)
  - bit4 overrun (sticky)
  - Sticky bits clear only on accepted CMD write or reset.
- 0x5 RDATA (RO): last read value
- 0x6 IRQ_PEND: [LANES-1:0], write-1-to-clear
- 0x7 IRQ_MASK: [LANES-1:0], 1 = enabled
- 0x8 VERSION (RO): 0x0002_0000 | LANES
- Unmapped addresses read 0; writes to them are ignored.

FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE:
- IDLE: an accepted CMD clears the sticky bits and sets busy.
  - lane >= LANES: go to DONE, set bad_lane; no master access.
  - READ or RMW: go to RD_REQ.
  - WRITE: go to WR_REQ.
- RD_REQ: m0_read=1 held until a cycle with m0_waitrequest=0, then go to RD_WAIT.
- RD_WAIT: on m0_readdatavalid, capture m0_readdata into RDATA.
  - READ: go to DONE.
  - RMW: compute wdata = (RDATA & ~RMW_MASK) | (WDATA & RMW_MASK), then go to WR_REQ.
- WR_REQ: m0_write=1 held until m0_waitrequest=0, then go to DONE.
- DONE: set done, clear busy, go to IDLE (one cycle).
- CMD write while busy: ignored, overrun set; the operation in progress is unaffected.
- Timeout: a phase counter resets on entry to RD_REQ, RD_WAIT or WR_REQ and increments each cycle in that state. When it reaches TIMEOUT:
  - deassert the request;
  - set timeout;
  - go to DONE; RDATA is unchanged.
- m0_readdatavalid arriving outside RD_WAIT is ignored.
- IRQ:
  - pend[i] sets on a rising edge of lane_irq[i] (previous-cycle register).
  - Set wins over a same-cycle W1C.
  - irq = |(pend & mask), registered.

## Timing
- Reset values:
  - all outputs 0 except m0_address = 0;
  - registers 0; state IDLE; previous-irq register 0.
- csr_readdatavalid asserts exactly 1 cycle after csr_read, with data; always ready (no waitrequest).
- CMD write at cycle T: m0_read/m0_write asserted at T+1; busy visible on a STATUS read issued at T+1.
- m0_address and m0_writedata are stable throughout any request assertion.
- Zero-wait single read: request at T+1, readdatavalid at T+2 gives DONE at T+3 and busy=0 from T+4.
- Zero-wait RMW: write request 1 cycle after readdatavalid.
- IRQ: lane_irq rising at cycle T gives pend set at T+1 and irq at T+2.
- Reset asserted mid-operation: requests drop the next cycle and the FSM returns to IDLE; there is no completion.

## Test plan
- Read lane 2, addr 0x05A; slave returns 0xDEADBEEF after 3 waitrequest cycles → m0_address = {2, 0x05A}; RDATA = 0xDEADBEEF; STATUS = 0x2.
- RMW lane 1: old 0xFFFF0000, WDATA 0x0000ABCD, MASK 0x00FF00FF → one read, then a write of 0xFF0000CD; STATUS = 0x2.
- Read with m0_waitrequest stuck high, TIMEOUT = 8 → m0_read drops after 8 cycles; STATUS = 0x6; a late readdatavalid leaves RDATA unchanged.
- ADDR lane = LANES with LANES = 4 → no m0_read/m0_write ever; STATUS = 0xA. A CMD write while a prior command is still busy → STATUS bit4 set, and only one transaction is issued.
- lane_irq[3] rising with IRQ_MASK = 0x8 → irq high 2 cycles later. W1C 0x8 in the same cycle as a new rising edge → pend[3] stays 1.
- Assert reset_reset during RD_WAIT → all outputs 0 the next cycle; STATUS = 0; a subsequent read completes normally.
